// File: rtl/activation_sequencer.sv
// Valid/ready stage that feeds an FP32 sigmoid, waits a settle time, and queues
// results in a small FIFO. Optional linear-activation bypass: define ACT_BYPASS_EN.
module activation_sequencer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  input  logic                       in_last,
`ifdef ACT_BYPASS_EN
  input  logic                       bypass,
`endif
  output logic [31:0]                sig_a,
  output logic [31:0]                sig_b,
  input  logic [31:0]                sig_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     sig_a_q, sig_a_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [32:0]     mem_q [DEPTH];
  logic            push, pop;
  logic [31:0]     cap_data;

`ifdef ACT_BYPASS_EN
  logic byp_q, byp_d;
  // Linear activation stores the operand itself, with identical timing.
  assign cap_data = byp_q ? sig_a_q : sig_out;
`else
  assign cap_data = sig_out;
`endif

  always_comb begin
    state_d  = state_q;
    sig_a_d  = sig_a_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    in_ready = 1'b0;
`ifdef ACT_BYPASS_EN
    byp_d    = byp_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so upstream never sees ready while held in reset.
        in_ready = rst_n && (fill_q < FW'(DEPTH));
        if (in_valid && in_ready) begin
          sig_a_d = in_data;
          last_d  = in_last;
          cnt_d   = CW'(SETTLE_CYCLES);
`ifdef ACT_BYPASS_EN
          byp_d   = bypass;
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = (fill_q != '0) && out_ready;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sig_a_q  <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
`ifdef ACT_BYPASS_EN
      byp_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sig_a_q  <= sig_a_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
`ifdef ACT_BYPASS_EN
      byp_q    <= byp_d;
`endif
    end
  end

  // FIFO storage is data only; validity lives in the pointers and fill count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_q, cap_data};
  end

  assign sig_a     = sig_a_q;
  assign sig_b     = 32'h0;
  assign out_valid = (fill_q != '0);
  assign out_data  = mem_q[rd_ptr_q][31:0];
  assign out_last  = mem_q[rd_ptr_q][32];
  assign fill      = fill_q;
  assign busy      = (state_q != S_IDLE) || (fill_q != '0);

endmodule
